// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: boot sequencer for the RV32I softcore.
// Holds the core in reset while it receives a length-prefixed byte image over
// a valid/ready stream. It packs the bytes into little-endian 32-bit words,
// writes them to instruction memory, then releases the core reset.
// Optional feature macro: BOOT_CHECKSUM_EN. When it is defined, the image
// ends with an XOR checksum byte that must match the data bytes.
module boot_loader_ctrl #(
    parameter int unsigned IM_WORDS = 1024,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              restart,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              core_resetb,
    output logic              busy,
    output logic              err
);

    // One extra bit so that word_cnt can reach IM_WORDS.
    localparam int unsigned CntW = ADDR_W + 1;

    typedef enum logic [2:0] {
        StLenLo, StLenHi, StData, StLast, StRun, StErr
`ifdef BOOT_CHECKSUM_EN
        , StCsum
`endif
    } state_e;

    // This is the state entered after the final data byte, or right after a
    // zero length.
`ifdef BOOT_CHECKSUM_EN
    localparam state_e StAfterData = StCsum;
`else
    localparam state_e StAfterData = StLast;
`endif

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [CntW-1:0]   word_cnt_q, word_cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic        accept;
    logic [15:0] len_full;
    logic        last_word;

    // restart blocks acceptance, so a byte in the restart cycle is dropped.
    assign accept    = rx_valid && rx_ready && !restart;
    assign len_full  = {rx_data, len_q[7:0]};
    assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state_q <= StLenLo;
        else         state_q <= state_d;
    end

    // Next-state logic; restart overrides everything.
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = StLenLo;
        end else begin
            unique case (state_q)
                StLenLo: if (accept) state_d = StLenHi;
                StLenHi: begin
                    if (accept) begin
                        if (len_full == 16'd0)               state_d = StAfterData;
                        else if (32'(len_full) > IM_WORDS)   state_d = StErr;
                        else                                 state_d = StData;
                    end
                end
                StData: begin
                    if (accept && byte_cnt_q == 2'd3 && last_word) state_d = StAfterData;
                end
`ifdef BOOT_CHECKSUM_EN
                StCsum: if (accept) state_d = (rx_data == xor_q) ? StLast : StErr;
`endif
                StLast:  state_d = StRun;
                StRun:   state_d = StRun;
                StErr:   state_d = StErr;
                default: state_d = StLenLo;
            endcase
        end
    end

    // Moore outputs, decoded from the state only.
    always_comb begin
        rx_ready    = 1'b0;
        core_resetb = 1'b0;
        busy        = 1'b1;
        err         = 1'b0;
        unique case (state_q)
            StLenLo, StLenHi, StData: rx_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            StCsum: rx_ready = 1'b1;
`endif
            StRun: begin
                core_resetb = 1'b1;
                busy        = 1'b0;
            end
            StErr: begin
                err  = 1'b1;
                busy = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath next-state: length capture, word assembly and the write strobe.
    always_comb begin
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef BOOT_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        if (restart) begin
            len_d      = '0;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            asm_d      = '0;
`ifdef BOOT_CHECKSUM_EN
            xor_d      = '0;
`endif
        end else if (accept) begin
            unique case (state_q)
                StLenLo: len_d[7:0]  = rx_data;
                StLenHi: len_d[15:8] = rx_data;
                StData: begin
`ifdef BOOT_CHECKSUM_EN
                    xor_d = xor_q ^ rx_data;
`endif
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            we_d       = 1'b1;
                            waddr_d    = word_cnt_q[ADDR_W-1:0];
                            wdata_d    = {rx_data, asm_q};
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef BOOT_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign im_we    = we_q;
    assign im_waddr = waddr_q;
    assign im_wdata = wdata_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl: scoreboard bench for boot_loader_ctrl.
// The expected memory writes are computed from each image and pushed into a
// queue. A monitor pops and compares them whenever im_we is seen.
module tb_boot_loader_ctrl;
    localparam int unsigned IM_WORDS = 1024;
    localparam int unsigned ADDR_W   = 10;

    logic              clk_tb = 1'b0;
    logic              resetb;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              restart;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              core_resetb;
    logic              busy;
    logic              err;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  img_q[$];
    int          checks = 0;
    int          errors = 0;

    boot_loader_ctrl #(.IM_WORDS(IM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk_tb), .resetb(resetb), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .restart(restart), .im_we(im_we), .im_waddr(im_waddr),
        .im_wdata(im_wdata), .core_resetb(core_resetb), .busy(busy), .err(err)
    );

    always #5 clk_tb = ~clk_tb;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    wr_t mon_e;
    always @(negedge clk_tb) begin
        if (resetb && im_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, none expected",
                         im_waddr, im_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(im_waddr), mon_e.addr);
                check("write_data", im_wdata, mon_e.data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_tb);
            #1;
        end
    endtask

    // Offers one byte and waits, with a time limit, until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            @(negedge clk_tb);
            if (rx_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL rx_ready_timeout: byte 0x%02h not accepted, ready stayed 0", b);
                rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk_tb);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk_tb);
        #1;
        restart = 1'b0;
    endtask

    // Reference model: image words are little-endian groups of four bytes.
    function automatic int unsigned word_of(input int i);
        return 32'(img_q[4*i]) + 32'(img_q[4*i+1]) * 256 +
               32'(img_q[4*i+2]) * 65536 + 32'(img_q[4*i+3]) * 16777216;
    endfunction

    // Sends img_q as a complete image, starting from LEN_LO, then checks the
    // release timing.
    task automatic run_image(input int gmax);
        int unsigned nw  = 32'(img_q.size()) / 4;
        logic [7:0]  sum = 8'h00;
        for (int i = 0; i < int'(nw); i++) exp_q.push_back('{addr: i, data: word_of(i)});
        idle($urandom_range(gmax, 0));
        send_byte(nw[7:0]);
        idle($urandom_range(gmax, 0));
        send_byte(nw[15:8]);
        for (int i = 0; i < img_q.size(); i++) begin
            idle($urandom_range(gmax, 0));
            send_byte(img_q[i]);
            sum = sum ^ img_q[i];
        end
`ifdef BOOT_CHECKSUM_EN
        idle($urandom_range(gmax, 0));
        send_byte(sum);
`endif
        // LAST cycle: the final write is in flight and the core is still in reset.
        check("last_core_resetb", 32'(core_resetb), 0);
        check("last_rx_ready", 32'(rx_ready), 0);
        idle(1);
        check("run_core_resetb", 32'(core_resetb), 1);
        check("run_busy", 32'(busy), 0);
        check("run_err", 32'(err), 0);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        idle(2);
        check("run_rx_ready", 32'(rx_ready), 0);
        rx_valid = 1'b0;
        check("writes_done", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        #23;
        check("reset_core_resetb", 32'(core_resetb), 0);
        check("reset_rx_ready", 32'(rx_ready), 1);
        check("reset_im_we", 32'(im_we), 0);
        check("reset_err", 32'(err), 0);
        check("reset_busy", 32'(busy), 1);
        check("reset_waddr", 32'(im_waddr), 0);
        check("reset_wdata", im_wdata, 0);
        resetb = 1'b1;
        @(posedge clk_tb);
        #1;

        // Two-word image, back to back, then with gaps.
        img_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'hC0, 8'h00};
        run_image(0);
        pulse_restart();
        check("restart_busy", 32'(busy), 1);
        run_image(5);
        pulse_restart();

        // Oversized length 0x0401 leads to the error state.
        send_byte(8'h01);
        send_byte(8'h04);
        check("ovf_err", 32'(err), 1);
        check("ovf_rx_ready", 32'(rx_ready), 0);
        check("ovf_core_resetb", 32'(core_resetb), 0);
        idle(3);
        check("ovf_err_held", 32'(err), 1);
        pulse_restart();
        check("ovf_restart_err", 32'(err), 0);
        check("ovf_restart_rx_ready", 32'(rx_ready), 1);
        img_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_image(2);
        pulse_restart();

        // Maximum length IM_WORDS is accepted and fills the whole memory.
        img_q.delete();
        for (int i = 0; i < 4 * int'(IM_WORDS); i++) img_q.push_back(8'($urandom));
        run_image(0);
        pulse_restart();

        // Restart mid-load: addr0 is written, and the partial word for addr1 is dropped.
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back('{addr: 0, data: 32'h44332211});
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        restart  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        @(posedge clk_tb);
        #1;
        restart  = 1'b0;
        rx_valid = 1'b0;
        check("midload_restart_rx_ready", 32'(rx_ready), 1);
        check("midload_restart_busy", 32'(busy), 1);
        check("midload_exp_empty", 32'(exp_q.size()), 0);
        img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_image(0);
        pulse_restart();
        check("run_restart_core_resetb", 32'(core_resetb), 0);
        check("run_restart_busy", 32'(busy), 1);

        // Zero-length image.
        img_q.delete();
        run_image(1);
        pulse_restart();

`ifdef BOOT_CHECKSUM_EN
        // A bad checksum byte leads to the error state after the data is written.
        send_byte(8'h01);
        send_byte(8'h00);
        exp_q.push_back('{addr: 0, data: 32'h44332211});
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h45);
        check("csum_bad_err", 32'(err), 1);
        check("csum_bad_core_resetb", 32'(core_resetb), 0);
        check("csum_bad_exp_empty", 32'(exp_q.size()), 0);
        pulse_restart();
`endif

        // Asynchronous reset while a write strobe is high.
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        #1;
        resetb = 1'b0;
        #1;
        check("areset_im_we", 32'(im_we), 0);
        check("areset_waddr", 32'(im_waddr), 0);
        check("areset_wdata", im_wdata, 0);
        check("areset_core_resetb", 32'(core_resetb), 0);
        check("areset_busy", 32'(busy), 1);
        #3;
        resetb = 1'b1;
        @(posedge clk_tb);
        #1;
        img_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_image(0);
        pulse_restart();

        // Random images with random gaps.
        for (int it = 0; it < 20; it++) begin
            int nw = $urandom_range(8, 0);
            img_q.delete();
            for (int i = 0; i < 4 * nw; i++) img_q.push_back(8'($urandom));
            run_image($urandom_range(3, 0));
            pulse_restart();
        end

        idle(3);
        check("final_exp_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
